ring_rr_arbiter: RTL and testbench

RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

---
 rtl/ring_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_ring_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ring_rr_arbiter
//  Purpose  : Four-requester round-robin arbiter built around a one-hot ring
//             pointer. A winner holds its grant until it drops its request or
//             until MAX_HOLD consecutive grant cycles have elapsed. A forced
//             end is flagged on preempt. Every grant is followed by exactly
//             one gap cycle.
//  Ports    : clk     - clock, rising edge active
//             rst     - asynchronous reset, active low
//             req     - [3:0] level-sensitive request lines
//             gnt     - [3:0] registered grant, one-hot or zero
//             ptr     - [3:0] registered one-hot ring priority pointer
//             busy    - high while a grant is being held
//             preempt - one-cycle pulse in the gap after a forced release
//  Revision : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [3:0] ptr,
   output logic       busy,
   output logic       preempt
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   // Counter value seen during the MAX_HOLD-th grant cycle (cleared on entry).
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [3:0]    ptr_q, ptr_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          preempt_q, preempt_d;

   logic [1:0]    ptr_pos;
   logic [1:0]    scan_idx;
   logic [3:0]    pick;

   // Binary position of the one-hot pointer.
   always_comb begin
      ptr_pos = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (ptr_q[i]) begin
            ptr_pos = 2'(i);
         end
      end
   end

   // Scan upward from the pointer with wrap-around. The loop runs from the
   // farthest offset down to zero so the nearest set request is written last.
   // Two-bit index arithmetic provides the wrap for free.
   always_comb begin
      pick     = 4'b0000;
      scan_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         scan_idx = ptr_pos + 2'(k);
         if (req[scan_idx]) begin
            pick           = 4'b0000;
            pick[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      case (state_q)
         GRANT: begin
            if ((req & gnt_q) == 4'b0000) begin
               // A voluntary drop wins even on the last allowed cycle.
               state_d = RELEASE;
               gnt_d   = 4'b0000;
               ptr_d   = {gnt_q[2:0], gnt_q[3]};
            end else if (hold_q == HOLD_LAST) begin
               state_d   = RELEASE;
               gnt_d     = 4'b0000;
               ptr_d     = {gnt_q[2:0], gnt_q[3]};
               preempt_d = 1'b1;
            end else begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: begin
            // IDLE and RELEASE arbitrate identically.
            if (req != 4'b0000) begin
               state_d = GRANT;
               gnt_d   = pick;
               hold_d  = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         ptr_q     <= 4'b0001;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt     = gnt_q;
   assign ptr     = ptr_q;
   assign busy    = (state_q == GRANT);
   assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_rr_arbiter
//  Purpose  : Self-checking bench for ring_rr_arbiter (MAX_HOLD = 8). A
//             cycle-level behavioural model tracks the current owner, its run
//             length and the pointer position as integers. One compare process
//             checks all outputs against it every falling edge. Literal
//             expectations pin the model at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;

   localparam int MH = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [3:0] ptr;
   logic       busy;
   logic       preempt;

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // Model state: owner index or -1, cycles held so far, pointer index,
   // and whether the last release was forced.
   int m_owner;
   int m_run;
   int m_ptr;
   bit m_pre;

   ring_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .ptr     (ptr),
      .busy    (busy),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_run   = 0;
      m_ptr   = 0;
      m_pre   = 1'b0;
   endtask

   // One rising edge of the arbiter's rules, using the requests seen at it.
   task automatic model_step(input logic [3:0] r);
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_pre   = 1'b0;
         end else if (m_run == MH) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_pre   = 1'b1;
         end else begin
            m_run = m_run + 1;
            m_pre = 1'b0;
         end
      end else begin
         m_pre = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               m_run   = 1;
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_gnt();
      return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
   endfunction

   // Single compare process: every falling edge while enabled.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_gnt", gnt, exp_gnt());
         check("model_ptr", ptr, 4'(1 << m_ptr));
         check("model_busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
         check("model_preempt", {3'b000, preempt}, {3'b000, m_pre});
      end
   end

   // Drive requests, let one rising edge pass, advance the model, and return
   // on the following falling edge.
   task automatic cycle(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      req = 4'b0000;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_gnt", gnt, 4'b0000);
      check("reset_ptr", ptr, 4'b0001);
      check("reset_busy", {3'b000, busy}, 4'b0000);
      check("reset_preempt", {3'b000, preempt}, 4'b0000);
      cmp_en = 1'b1;
      rst    = 1'b1;

      // Basic grant, release gap and pointer advance.
      cycle(4'b1010);
      check("first_gnt", gnt, 4'b0010);
      cycle(4'b1000);
      check("release_gnt", gnt, 4'b0000);
      check("release_ptr", ptr, 4'b0100);
      cycle(4'b1000);
      check("second_gnt", gnt, 4'b1000);
      cycle(4'b0000);
      cycle(4'b0000);

      // Single requester held three cycles.
      repeat (3) cycle(4'b0100);
      check("single_gnt", gnt, 4'b0100);
      cycle(4'b0000);
      check("single_drop_gnt", gnt, 4'b0000);
      check("single_ptr", ptr, 4'b1000);
      check("single_preempt", {3'b000, preempt}, 4'b0000);
      cycle(4'b0000);

      // Drop coinciding with the MAX_HOLD-th grant cycle.
      repeat (MH) cycle(4'b1000);
      check("coinc_held_gnt", gnt, 4'b1000);
      cycle(4'b0000);
      check("coinc_gnt", gnt, 4'b0000);
      check("coinc_preempt", {3'b000, preempt}, 4'b0000);
      check("coinc_ptr", ptr, 4'b0001);
      cycle(4'b0000);

      // Late arrivals must not disturb a running grant.
      cycle(4'b0001);
      repeat (3) cycle(4'b1001);
      check("nonint_gnt", gnt, 4'b0001);
      cycle(4'b1000);
      check("nonint_gap", gnt, 4'b0000);
      cycle(4'b1000);
      check("nonint_next", gnt, 4'b1000);
      cycle(4'b0000);
      cycle(4'b0000);

      // Saturation: every requester in turn, forced off after MAX_HOLD.
      cycle(4'b1111);
      check("sat_first", gnt, 4'b0001);
      repeat (MH - 1) cycle(4'b1111);
      check("sat_held", gnt, 4'b0001);
      cycle(4'b1111);
      check("sat_gap_gnt", gnt, 4'b0000);
      check("sat_gap_preempt", {3'b000, preempt}, 4'b0001);
      check("sat_gap_ptr", ptr, 4'b0010);
      cycle(4'b1111);
      check("sat_second", gnt, 4'b0010);
      check("sat_second_preempt", {3'b000, preempt}, 4'b0000);
      repeat (27) cycle(4'b1111);
      check("sat_wrap", gnt, 4'b0001);
      cycle(4'b0000);
      cycle(4'b0000);

      // Asynchronous reset between edges in the middle of a grant.
      cycle(4'b0100);
      cycle(4'b0100);
      check("pre_async_gnt", gnt, 4'b0100);
      #2;
      rst = 1'b0;
      #1;
      check("async_gnt", gnt, 4'b0000);
      check("async_ptr", ptr, 4'b0001);
      check("async_busy", {3'b000, busy}, 4'b0000);
      check("async_preempt", {3'b000, preempt}, 4'b0000);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle(4'b0010);
      check("post_reset_gnt", gnt, 4'b0010);

      // Mixed patterns checked by the model only.
      cycle(4'b0110);
      cycle(4'b0100);
      cycle(4'b0101);
      cycle(4'b0101);
      cycle(4'b0001);
      cycle(4'b1001);
      cycle(4'b1000);
      cycle(4'b0000);
      cycle(4'b0000);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
